// File: rtl/uart_proto_pkg.sv
// Shared UART protocol definitions: ASCII constants, error codes and hex
// helpers. Used by the RX line parser and the TX challenge formatter.
package uart_proto_pkg;

    localparam logic [7:0] CHR_R     = 8'h52;
    localparam logic [7:0] CHR_E     = 8'h45;
    localparam logic [7:0] CHR_S     = 8'h53;
    localparam logic [7:0] CHR_P     = 8'h50;
    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_Y     = 8'h59;
    localparam logic [7:0] CHR_N     = 8'h4E;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_BAD_PREFIX = 3'd1;
    localparam logic [2:0] ERR_BAD_HEX    = 3'd2;
    localparam logic [2:0] ERR_BAD_EOL    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

    // lower selects whether 'a'-'f' count as hex digits.
    function automatic logic is_hex(input logic [7:0] c, input logic lower);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (lower && c >= 8'h61 && c <= 8'h66);
    endfunction

    // Only meaningful when is_hex() is true for c.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        logic [7:0] v;
        if (c <= 8'h39)      v = c - 8'h30;
        else if (c <= 8'h46) v = c - 8'h37;
        else                 v = c - 8'h57;
        return v[3:0];
    endfunction

endpackage

// File: rtl/resp_line_parser.sv
// resp_line_parser: RX-side line parser feeding the challenge-response auth FSM.
// Decodes "RESP:YYYY\n" into a 16-bit value, classifies malformed/late lines,
// and decodes single-character Y/N commands while idle.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   rx_data, rx_valid    byte stream from uart_rx
//   arm                  pulse: expect a RESP line next
//   flush                pulse: abort silently to IDLE
//   resp_value/valid     parsed value (held) + 1-cycle pulse
//   resp_error/err_code  1-cycle error pulse + held error code
//   cmd_char/cmd_valid   'Y'/'N' (upper case, held) + 1-cycle pulse
//   busy                 parser not in IDLE
module resp_line_parser
    import uart_proto_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES   = 24'd12_000_000,
    parameter int          MAX_DISCARD      = 16,   // 1..31
    parameter bit          ACCEPT_LOWER_HEX = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        arm,
    input  logic        flush,
    output logic [15:0] resp_value,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [2:0]  err_code,
    output logic [7:0]  cmd_char,
    output logic        cmd_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PREFIX, HEX, EOL, DISCARD} state_t;

    localparam logic [4:0] DISC_LIM = 5'(MAX_DISCARD);

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;        // prefix idx / digit idx / CR-seen flag / discard count
    logic [23:0] timer, timer_n;
    logic [15:0] acc, acc_n;
    logic [15:0] resp_value_n;
    logic [2:0]  err_code_n;
    logic [7:0]  cmd_char_n;
    logic        resp_valid_n, resp_error_n, cmd_valid_n;
    logic [7:0]  exp_chr;
    logic [7:0]  up_chr;

    always_comb begin
        case (cnt)
            5'd0:    exp_chr = CHR_R;
            5'd1:    exp_chr = CHR_E;
            5'd2:    exp_chr = CHR_S;
            5'd3:    exp_chr = CHR_P;
            default: exp_chr = CHR_COLON;
        endcase
    end

    // Clearing bit 5 upper-cases letters; only used where the byte is Y/y/N/n.
    assign up_chr = rx_data & 8'hDF;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            timer      <= '0;
            acc        <= '0;
            resp_value <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            err_code   <= ERR_NONE;
            cmd_char   <= '0;
            cmd_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            timer      <= timer_n;
            acc        <= acc_n;
            resp_value <= resp_value_n;
            resp_valid <= resp_valid_n;
            resp_error <= resp_error_n;
            err_code   <= err_code_n;
            cmd_char   <= cmd_char_n;
            cmd_valid  <= cmd_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        acc_n        = acc;
        resp_value_n = resp_value;
        err_code_n   = err_code;
        cmd_char_n   = cmd_char;
        resp_valid_n = 1'b0;
        resp_error_n = 1'b0;
        cmd_valid_n  = 1'b0;
        // Timer only runs while a line is in progress and saturates at the limit.
        if (state == IDLE)                timer_n = '0;
        else if (timer != TIMEOUT_CYCLES) timer_n = timer + 24'd1;
        else                              timer_n = timer;

        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            timer_n = '0;
        end else if (arm) begin
            state_n = PREFIX;
            cnt_n   = '0;
            timer_n = '0;
            acc_n   = '0;
        end else if (rx_valid) begin
            timer_n = '0;
            case (state)
                IDLE: begin
                    if (up_chr == CHR_Y || up_chr == CHR_N) begin
                        cmd_char_n  = up_chr;
                        cmd_valid_n = 1'b1;
                    end
                end
                PREFIX: begin
                    if (rx_data != exp_chr) begin
                        resp_error_n = 1'b1;
                        err_code_n   = ERR_BAD_PREFIX;
                        state_n      = DISCARD;
                        cnt_n        = '0;
                    end else if (cnt == 5'd4) begin
                        state_n = HEX;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                HEX: begin
                    if (is_hex(rx_data, ACCEPT_LOWER_HEX)) begin
                        acc_n = {acc[11:0], hex_to_nibble(rx_data)};
                        if (cnt == 5'd3) begin
                            state_n = EOL;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 5'd1;
                        end
                    end else begin
                        resp_error_n = 1'b1;
                        err_code_n   = ERR_BAD_HEX;
                        state_n      = DISCARD;
                        cnt_n        = '0;
                    end
                end
                EOL: begin
                    if (rx_data == CHR_LF) begin
                        resp_value_n = acc;
                        resp_valid_n = 1'b1;
                        state_n      = IDLE;
                        cnt_n        = '0;
                    end else if (rx_data == CHR_CR && !cnt[0]) begin
                        cnt_n = 5'd1;   // one CR tolerated
                    end else begin
                        resp_error_n = 1'b1;
                        err_code_n   = ERR_BAD_EOL;
                        state_n      = DISCARD;
                        cnt_n        = '0;
                    end
                end
                DISCARD: begin
                    if (rx_data == CHR_LF || cnt + 5'd1 == DISC_LIM) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end else if (state != IDLE && timer == TIMEOUT_CYCLES) begin
            if (state != DISCARD) begin
                resp_error_n = 1'b1;
                err_code_n   = ERR_TIMEOUT;
            end
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

endmodule

// File: tb/tb_resp_line_parser.sv
module tb_resp_line_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        arm = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] resp_value;
    logic        resp_valid;
    logic        resp_error;
    logic [2:0]  err_code;
    logic [7:0]  cmd_char;
    logic        cmd_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // cumulative pulse counts, sampled on the falling edge
    int n_rv = 0, n_re = 0, n_cv = 0, n_multi = 0;
    int s_rv, s_re, s_cv;

    resp_line_parser #(.TIMEOUT_CYCLES(24'd1000)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .arm(arm), .flush(flush), .resp_value(resp_value), .resp_valid(resp_valid),
        .resp_error(resp_error), .err_code(err_code), .cmd_char(cmd_char),
        .cmd_valid(cmd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_valid) n_rv++;
        if (resp_error) n_re++;
        if (cmd_valid)  n_cv++;
        if (int'(resp_valid) + int'(resp_error) + int'(cmd_valid) > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_rv = n_rv; s_re = n_re; s_cv = n_cv;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rv",   {31'd0, resp_valid}, 0);
        chk("rst_val",  {16'd0, resp_value}, 0);
        chk("rst_ec",   {29'd0, err_code}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good line with a lower-case digit
        snap();
        pulse_arm();
        send_str("RESP:1F0a\n");
        chk("t1_rv_lat", {31'd0, resp_valid}, 1);
        chk("t1_val",    {16'd0, resp_value}, 32'h1F0A);
        @(negedge clk);
        chk("t1_nrv",  n_rv - s_rv, 1);
        chk("t1_nre",  n_re - s_re, 0);
        chk("t1_busy", {31'd0, busy}, 0);

        // 2: bad hex digit, rest swallowed
        snap();
        pulse_arm();
        send_str("RESP:12G");
        chk("t2_re", {31'd0, resp_error}, 1);
        chk("t2_ec", {29'd0, err_code}, 2);
        send_str("4");
        chk("t2_busy_mid", {31'd0, busy}, 1);
        send_str("\n");
        chk("t2_busy", {31'd0, busy}, 0);
        chk("t2_nre",  n_re - s_re, 1);
        chk("t2_nrv",  n_rv - s_rv, 0);

        // 3: commands in IDLE
        snap();
        send_byte("y");
        chk("t3_cv1", {31'd0, cmd_valid}, 1);
        chk("t3_c1",  {24'd0, cmd_char}, 32'h59);
        send_byte("n");
        chk("t3_c2",  {24'd0, cmd_char}, 32'h4E);
        send_byte("x");
        chk("t3_ncv", n_cv - s_cv, 2);

        // 4: timeout after prefix
        snap();
        pulse_arm();
        send_str("RESP:");
        repeat (900) @(negedge clk);
        chk("t4_early", {31'd0, busy}, 1);
        begin
            int k = 0;
            while (busy && k < 300) begin @(negedge clk); k++; end
            chk("t4_bound", {31'd0, busy}, 0);
        end
        repeat (5) @(negedge clk);
        chk("t4_ec",  {29'd0, err_code}, 4);
        chk("t4_nre", n_re - s_re, 1);

        // 5: re-arm mid-line, then CRLF line
        snap();
        pulse_arm();
        send_str("RES");
        pulse_arm();
        send_str("RESP:ABCD\r\n");
        @(negedge clk);
        chk("t5_val", {16'd0, resp_value}, 32'hABCD);
        chk("t5_nre", n_re - s_re, 0);
        chk("t5_nrv", n_rv - s_rv, 1);

        // bad EOL: second CR
        snap();
        pulse_arm();
        send_str("RESP:1234\r\r");
        chk("eol_ec",  {29'd0, err_code}, 3);
        send_str("\n");
        chk("eol_nrv", n_rv - s_rv, 0);
        chk("eol_val", {16'd0, resp_value}, 32'hABCD);

        // 6A: flush mid-hex
        snap();
        pulse_arm();
        send_str("RESP:00");
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6a_busy", {31'd0, busy}, 0);
        chk("t6a_pls",  (n_rv - s_rv) + (n_re - s_re) + (n_cv - s_cv), 0);

        // 6B: no command decode in DISCARD; discard byte limit
        snap();
        pulse_arm();
        send_str("RESX");
        chk("t6b_ec", {29'd0, err_code}, 1);
        send_byte("Y");
        chk("t6b_ncv", n_cv - s_cv, 0);
        for (int i = 0; i < 14; i++) send_byte("a");
        chk("disc_15", {31'd0, busy}, 1);
        send_byte("a");
        chk("disc_16", {31'd0, busy}, 0);
        send_byte("N");
        chk("t6b_cmd", {24'd0, cmd_char}, 32'h4E);
        chk("t6b_nre", n_re - s_re, 1);

        // 6C: async reset mid-hex
        pulse_arm();
        send_str("RESP:12");
        #2 rst_n = 1'b0;
        #1;
        chk("t6c_busy", {31'd0, busy}, 0);
        chk("t6c_val",  {16'd0, resp_value}, 0);
        chk("t6c_ec",   {29'd0, err_code}, 0);
        chk("t6c_cmd",  {24'd0, cmd_char}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("one_hot", n_multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1);
    end

endmodule
